// File: rtl/switch_port.sv
// switch_port: synchronise and debounce a bank of switches into a committed word with a sticky new-data flag
module switch_port #(
  parameter int WORD_W    = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] switches,
  input  logic              s_rd,
  output logic [WORD_W-1:0] Sdata,
  output logic              s_new
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  typedef enum logic {STABLE, SETTLING} state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] sync1_q, sync2_q;
  logic [WORD_W-1:0] cand_q, cand_d;
  logic [WORD_W-1:0] sdata_q, sdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              new_q, new_d;
  // two-flop synchroniser for the raw, bouncing switch levels
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= switches;
      sync2_q <= sync1_q;
    end
  end
  // debounce decision: a whole word must hold for DB_CYCLES settling cycles before commit; commit beats read-clear
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    sdata_d = sdata_q;
    new_d   = s_rd ? 1'b0 : new_q;
    if (state_q == STABLE) begin
      if (sync2_q != sdata_q) begin
        state_d = SETTLING;
        cand_d  = sync2_q;
        cnt_d   = '0;
      end
    end else if (sync2_q == sdata_q) begin
      state_d = STABLE;
    end else if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      sdata_d = cand_q;
      new_d   = 1'b1;
      state_d = STABLE;
    end
  end
  // debounce state, candidate, counter and committed outputs
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= STABLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      sdata_q <= '0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      sdata_q <= sdata_d;
      new_q   <= new_d;
    end
  end
  assign Sdata = sdata_q;
  assign s_new = new_q;
endmodule

// File: tb/tb_switch_port.sv
// tb_switch_port: directed and randomised checks of switch_port against a run-length debounce model
module tb_switch_port;
  localparam int W  = 8;
  localparam int DB = 4;
  logic         clock = 1'b0;
  logic         n_reset = 1'b1;
  logic [W-1:0] switches = '0;
  logic         s_rd = 1'b0;
  logic [W-1:0] Sdata;
  logic         s_new;
  int checks = 0;
  int errors = 0;

  switch_port #(.WORD_W(W), .DB_CYCLES(DB)) dut (
    .clock(clock), .n_reset(n_reset), .switches(switches),
    .s_rd(s_rd), .Sdata(Sdata), .s_new(s_new)
  );

  always #5 clock = ~clock;

  // reference: a word commits once the synchronised value, different from the committed one,
  // has been seen on DB+1 consecutive edges
  logic [W-1:0] m_s1, m_s2, m_last, m_data;
  logic         m_new;
  int           m_run;
  wire m_commit = (m_s2 != m_data) && (m_s2 == m_last) && (m_run == DB);
  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_s1 <= '0; m_s2 <= '0; m_last <= '0; m_data <= '0; m_new <= 1'b0; m_run <= 0;
    end else begin
      m_s1   <= switches;
      m_s2   <= m_s1;
      m_last <= m_s2;
      m_run  <= (m_s2 == m_data || m_commit) ? 0 : (m_s2 == m_last && m_run > 0) ? m_run + 1 : 1;
      if (m_commit) m_data <= m_s2;
      m_new  <= m_commit | (m_new & ~s_rd);
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    switches = '0;
    s_rd = 1'b0;
    n_reset = 1'b0;
    repeat (2) tick();
    n_reset = 1'b1;
  endtask

  task automatic test_reset;
    switches = 8'hFF;
    repeat (3) tick();
    n_reset = 1'b0;
    #1;
    checks++;
    if (Sdata !== 8'h00 || s_new !== 1'b0) begin
      errors++;
      $display("FAIL reset Sdata=%h s_new=%b exp 00/0", Sdata, s_new);
    end
    do_reset();
  endtask

  task automatic test_latency;
    do_reset();
    switches = 8'hA5;
    for (int e = 0; e <= 6; e++) begin
      tick();
      checks++;
      if (Sdata !== (e < 6 ? 8'h00 : 8'hA5) || s_new !== (e == 6)) begin
        errors++;
        $display("FAIL latency edge%0d Sdata=%h s_new=%b exp %h/%b", e, Sdata, s_new,
                 (e < 6 ? 8'h00 : 8'hA5), (e == 6));
      end
    end
  endtask

  task automatic test_read;
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    checks++;
    if (s_new !== 1'b0 || Sdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_clear Sdata=%h s_new=%b exp A5/0", Sdata, s_new);
    end
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    checks++;
    if (s_new !== 1'b0 || Sdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_idle Sdata=%h s_new=%b exp A5/0", Sdata, s_new);
    end
    switches = 8'h5A;
    for (int e = 0; e <= 6; e++) begin
      s_rd = (e == 6);
      tick();
    end
    s_rd = 1'b0;
    checks++;
    if (s_new !== 1'b1 || Sdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_vs_commit Sdata=%h s_new=%b exp 5A/1", Sdata, s_new);
    end
    tick();
    checks++;
    if (s_new !== 1'b1) begin
      errors++;
      $display("FAIL sticky s_new=%b exp 1", s_new);
    end
  endtask

  task automatic test_glitch;
    int bad = 0;
    do_reset();
    switches = 8'h01;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) switches = 8'h00;
      tick();
      if (Sdata !== 8'h00 || s_new !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch bad_cycles=%0d exp 0 (Sdata=%h s_new=%b)", bad, Sdata, s_new);
    end
  endtask

  task automatic test_bounce;
    int first = -1;
    int pulses = 0;
    logic prev;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      switches = (i % 2 == 0) ? 8'h0F : 8'h00;
      tick();
    end
    prev = s_new;
    switches = 8'h0F;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (s_new && !prev) pulses++;
      if (Sdata === 8'h0F && first < 0) first = e;
      prev = s_new;
    end
    checks++;
    if (first != 6) begin
      errors++;
      $display("FAIL bounce_edge got=%0d exp 6", first);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulses got=%0d exp 1", pulses);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    switches = 8'h3C;
    repeat (4) tick();
    n_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(); else #1;
      checks++;
      if (Sdata !== 8'h00 || s_new !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold%0d Sdata=%h s_new=%b exp 00/0", i, Sdata, s_new);
      end
    end
    n_reset = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      checks++;
      if (Sdata !== (e < 6 ? 8'h00 : 8'h3C) || s_new !== (e == 6)) begin
        errors++;
        $display("FAIL reset_mid edge%0d Sdata=%h s_new=%b exp %h/%b", e, Sdata, s_new,
                 (e < 6 ? 8'h00 : 8'h3C), (e == 6));
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] vals [4] = '{8'h00, 8'h0F, 8'hA5, 8'hFF};
    do_reset();
    for (int s = 0; s < 80; s++) begin
      switches = vals[$urandom_range(0, 3)];
      for (int k = $urandom_range(1, 9); k > 0; k--) begin
        s_rd = ($urandom_range(0, 3) == 0);
        tick();
        checks++;
        if (Sdata !== m_data || s_new !== m_new) begin
          errors++;
          $display("FAIL random seg%0d Sdata=%h s_new=%b exp %h/%b", s, Sdata, s_new, m_data, m_new);
        end
      end
    end
    s_rd = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_latency();
    test_read();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/switch_port.md
SWITCH_PORT -- requirements
Module: switch_port

Interface
REQ-001 SHALL have parameter WORD_W, default 8, data width of switch bank and Sdata.
REQ-002 SHALL have parameter DB_CYCLES, default 16, consecutive stable cycles required before commit; legal range 2..65535.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port n_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port switches  input  WORD_W  raw, asynchronous, bouncing switch levels.
REQ-006 SHALL have port s_rd  input  1  read acknowledge; high for one cycle when the processor reads the switch address.
REQ-007 SHALL have port Sdata  output  WORD_W  debounced, committed switch word, registered.
REQ-008 SHALL have port s_new  output  1  sticky flag; Sdata committed since last s_rd.

Function
REQ-009 SHALL pass each switches bit through a two-flop synchroniser (sync1, then sync2); only sync2 is used downstream.
REQ-010 SHALL implement FSM states STABLE and SETTLING, plus candidate register (WORD_W) and counter (width clog2(DB_CYCLES)).
REQ-011 STABLE: sync2 == Sdata -> remain; sync2 != Sdata -> go SETTLING, candidate <= sync2, counter <= 0.
REQ-012 SETTLING, sync2 == Sdata -> abort to STABLE, Sdata and s_new unchanged (glitch rejected).
REQ-013 SETTLING, sync2 != Sdata and sync2 != candidate -> candidate <= sync2, counter <= 0, remain SETTLING.
REQ-014 SETTLING, sync2 == candidate, counter < DB_CYCLES-1 -> counter <= counter+1.
REQ-015 SETTLING, sync2 == candidate, counter == DB_CYCLES-1 -> Sdata <= candidate, s_new <= 1, go STABLE.
REQ-016 Latency: raw change first sampled at edge 0 and held -> Sdata updates at edge DB_CYCLES+2; no earlier or later.
REQ-017 Counter SHALL never wrap; it only reaches DB_CYCLES-1 in SETTLING and is reloaded on state entry.
REQ-018 s_new SHALL clear on the edge where s_rd is high; if a commit and s_rd occur on the same edge, s_new SHALL be 1 (set wins).
REQ-019 s_rd while s_new is 0 SHALL have no effect; s_rd SHALL never alter Sdata, candidate, counter or FSM state.
REQ-020 Multi-bit changes SHALL be committed as one word; partial-word commits are forbidden.
REQ-021 Sdata SHALL be driven directly from a register (no combinational path from switches or s_rd).

Reset
REQ-022 n_reset low SHALL asynchronously force sync1, sync2, candidate, Sdata to 0, counter to 0, s_new to 0, FSM to STABLE.
REQ-023 Reset asserted mid-SETTLING SHALL discard the pending candidate; no commit occurs after release until a full new debounce window completes.
REQ-024 After reset release with switches non-zero, Sdata SHALL update at edge DB_CYCLES+2 after release, with s_new set.

Verification (DB_CYCLES=4, WORD_W=8)
REQ-025 Reset, switches=8'hA5 held from edge 0 -> Sdata=8'h00 through edge 5, Sdata=8'hA5 and s_new=1 at edge 6.
REQ-026 Sdata=8'h00 stable, switches pulse 8'h01 for 3 cycles then return to 8'h00 -> Sdata stays 8'h00, s_new stays 0.
REQ-027 Bounce: switches toggle 8'h0F/8'h00 every cycle for 6 cycles then hold 8'h0F -> single commit to 8'h0F exactly DB_CYCLES+2 edges after final transition; s_new pulses to 1 once.
REQ-028 s_new=1, s_rd high one cycle -> s_new=0 next edge, Sdata unchanged; s_rd coincident with commit edge -> s_new=1.
REQ-029 Change 8'h00->8'h3C, assert n_reset low at edge 4 (mid-SETTLING), release -> all outputs 0 during reset; 8'h3C commits DB_CYCLES+2 edges after release.
